// File: rtl/uart_packet_rx.sv
// Packet framer behind the UART receiver: SOF, LEN, payload, CHK.
// Buffers the payload and streams it out only after the checksum verifies.
module uart_packet_rx #(
  parameter int unsigned MAX_LEN = 16,
  parameter logic [7:0]  SOF     = 8'hAA,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_err,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       pkt_ok,
  output logic [7:0] pkt_len,
  output logic       err_valid,
  output logic [1:0] err_code,
  output logic       overrun
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHK, DRAIN} state_t;
  typedef enum logic [1:0] {ERR_CHK, ERR_LEN, ERR_TIMEOUT, ERR_LINE} err_t;

  state_t        state;
  logic [7:0]    len;
  logic [7:0]    wptr;
  logic [7:0]    rptr;
  logic [7:0]    sum;
  logic [7:0]    sum_next;
  logic [TW-1:0] timer;
  logic [7:0]    mem [MAX_LEN];

  assign sum_next  = sum + rx_data;
  assign out_valid = (state == DRAIN);
  assign out_last  = out_valid && (rptr == len - 8'd1);

  // Gated so the stream data reads as zero outside DRAIN (and during reset).
  always_comb begin
    out_data = '0;
    if (out_valid) out_data = mem[rptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (state == PAYLOAD && rx_valid && !rx_err) mem[wptr[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      len       <= '0;
      wptr      <= '0;
      rptr      <= '0;
      sum       <= '0;
      timer     <= '0;
      pkt_ok    <= 1'b0;
      pkt_len   <= '0;
      err_valid <= 1'b0;
      err_code  <= '0;
      overrun   <= 1'b0;
    end else begin
      pkt_ok    <= 1'b0;
      err_valid <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid) timer <= '0;
      case (state)
        IDLE: begin
          if (rx_valid && rx_data == SOF) begin
            state <= LEN;
            sum   <= '0;
            wptr  <= '0;
          end
        end
        DRAIN: begin
          if (rx_valid) overrun <= 1'b1;
          if (out_ready) begin
            rptr <= rptr + 8'd1;
            if (rptr == len - 8'd1) state <= IDLE;
          end
        end
        default: begin
          // Mid-packet: a line error outranks a byte in the same cycle.
          if (rx_err) begin
            err_valid <= 1'b1;
            err_code  <= ERR_LINE;
            state     <= IDLE;
            timer     <= '0;
          end else if (rx_valid) begin
            case (state)
              LEN: begin
                len <= rx_data;
                sum <= rx_data;
                if (rx_data > 8'(MAX_LEN)) begin
                  err_valid <= 1'b1;
                  err_code  <= ERR_LEN;
                  state     <= IDLE;
                end else if (rx_data == 8'd0) begin
                  state <= CHK;
                end else begin
                  state <= PAYLOAD;
                end
              end
              PAYLOAD: begin
                wptr <= wptr + 8'd1;
                sum  <= sum_next;
                if (wptr == len - 8'd1) state <= CHK;
              end
              CHK: begin
                sum <= sum_next;
                if (sum_next == 8'd0) begin
                  pkt_ok  <= 1'b1;
                  pkt_len <= len;
                  rptr    <= '0;
                  state   <= (len != 8'd0) ? DRAIN : IDLE;
                end else begin
                  err_valid <= 1'b1;
                  err_code  <= ERR_CHK;
                  state     <= IDLE;
                end
              end
              default: state <= IDLE;
            endcase
          end else if (timer == TW'(TIMEOUT - 1)) begin
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= IDLE;
            timer     <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_packet_rx.sv
// Directed bench for uart_packet_rx with an event/data scoreboard.
module tb_uart_packet_rx;

  localparam int unsigned TO = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_err = 1'b0;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       pkt_ok;
  logic [7:0] pkt_len;
  logic       err_valid;
  logic [1:0] err_code;
  logic       overrun;

  int n_assert = 0;
  int n_fail   = 0;
  int n_xfer   = 0;

  // kind 0: pkt_ok (val = len), 1: err_valid (val = code), 2: overrun
  typedef struct {int kind; int val;} ev_t;
  ev_t        evq[$];
  logic [8:0] dq[$];
  ev_t        mon_e;
  logic [8:0] mon_d;

  uart_packet_rx #(.MAX_LEN(16), .SOF(8'hAA), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .pkt_ok(pkt_ok), .pkt_len(pkt_len), .err_valid(err_valid), .err_code(err_code),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic expect_ev(input int k, input int v);
    evq.push_back('{kind: k, val: v});
  endtask

  task automatic expect_3byte();
    dq.push_back({1'b0, 8'h11});
    dq.push_back({1'b0, 8'h22});
    dq.push_back({1'b1, 8'h33});
  endtask

  task automatic send_3byte();
    send(8'hAA); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h97);
  endtask

  task automatic wait_done(input int budget);
    bit done;
    done = (evq.size() == 0 && dq.size() == 0);
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #1;
      done = (evq.size() == 0 && dq.size() == 0);
    end
    check("scoreboard_drained", 32'(done), 32'd1);
  endtask

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    check("ok_err_exclusive", 32'(pkt_ok && err_valid), 32'd0);
    if (pkt_ok) begin
      if (evq.size() == 0) check("unexpected_pkt_ok", 32'd1, 32'd0);
      else begin
        mon_e = evq.pop_front();
        check("pkt_ok_order", 32'd0, mon_e.kind);
        check("pkt_len", 32'(pkt_len), mon_e.val);
        check("valid_with_pkt_ok", 32'(out_valid), 32'(mon_e.val != 0));
      end
    end
    if (err_valid) begin
      if (evq.size() == 0) check("unexpected_err", 32'(err_code), 32'hFF);
      else begin
        mon_e = evq.pop_front();
        check("err_order", 32'd1, mon_e.kind);
        check("err_code", 32'(err_code), mon_e.val);
      end
    end
    if (overrun) begin
      if (evq.size() == 0) check("unexpected_overrun", 32'd1, 32'd0);
      else begin
        mon_e = evq.pop_front();
        check("overrun_order", 32'd2, mon_e.kind);
      end
    end
    if (out_valid) begin
      if (dq.size() == 0) check("unexpected_out_valid", 32'(out_data), 32'h1FF);
      else begin
        mon_d = dq[0];
        check("out_data", 32'(out_data), 32'(mon_d[7:0]));
        check("out_last", 32'(out_last), 32'(mon_d[8]));
        if (out_ready) begin
          void'(dq.pop_front());
          n_xfer++;
        end
      end
    end else begin
      check("last_without_valid", 32'(out_last), 32'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    int n;
    bit seen;

    #12;
    check("reset_outputs",
          32'({out_valid, pkt_ok, err_valid, overrun, out_last, err_code, pkt_len, out_data}), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // Good packet, consumer always ready: back-to-back stream.
    expect_ev(0, 3); expect_3byte();
    x0 = n_xfer;
    send_3byte();
    check("valid_same_cycle_as_ok", 32'(out_valid), 32'd1);
    repeat (3) @(posedge clk); #1;
    check("stream_consecutive", 32'(dq.size()), 32'd0);
    check("stream_xfers", 32'(n_xfer - x0), 32'd3);
    check("stream_end_idle", 32'(out_valid), 32'd0);

    // Backpressure: stall 5 cycles, then toggle ready.
    out_ready = 1'b0;
    expect_ev(0, 3); expect_3byte();
    x0 = n_xfer;
    send_3byte();
    repeat (5) @(posedge clk); #1;
    check("stall_no_xfer", 32'(n_xfer - x0), 32'd0);
    check("stall_valid_held", 32'(out_valid), 32'd1);
    for (int i = 0; i < 40 && dq.size() != 0; i++) begin
      out_ready = ~out_ready;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    check("bp_xfers", 32'(n_xfer - x0), 32'd3);
    check("bp_idle", 32'(out_valid), 32'd0);
    wait_done(4);

    // Bad checksum, then empty good packet.
    expect_ev(1, 0);
    send(8'hAA); send(8'h02); send(8'h01); send(8'h02); send(8'h00);
    wait_done(4);
    expect_ev(0, 0);
    send(8'hAA); send(8'h00); send(8'h00);
    wait_done(4);

    // Oversized LEN, then junk and a one-byte packet.
    expect_ev(1, 1);
    send(8'hAA); send(8'h11);
    check("len_err_timing", 32'(err_valid), 32'd1);
    expect_ev(0, 1); dq.push_back({1'b1, 8'h7F});
    send(8'h55); send(8'hAA); send(8'h01); send(8'h7F); send(8'h80);
    wait_done(6);

    // Inter-byte timeout.
    expect_ev(1, 2);
    send(8'hAA); send(8'h02); send(8'h01);
    n = 0; seen = 1'b0;
    for (int i = 1; i <= int'(TO) + 10 && !seen; i++) begin
      @(negedge clk);
      if (err_valid) begin seen = 1'b1; n = i; end
    end
    check("timeout_cycles", 32'(n), 32'(TO + 1));
    @(posedge clk); #1;
    wait_done(4);

    // Line error with a simultaneous byte; the byte must not be parsed.
    expect_ev(1, 3);
    send(8'hAA); send(8'h02);
    rx_err = 1'b1; send(8'h05); rx_err = 1'b0;
    expect_ev(0, 1); dq.push_back({1'b1, 8'h7F});
    send(8'hAA); send(8'h01); send(8'h7F); send(8'h80);
    wait_done(6);
    rx_err = 1'b1; @(posedge clk); #1 rx_err = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("idle_rx_err_ignored", 32'(evq.size()), 32'd0);

    // Overrun while draining.
    out_ready = 1'b0;
    expect_ev(0, 3); expect_ev(2, 0); expect_ev(2, 0); expect_3byte();
    send_3byte();
    repeat (2) @(posedge clk); #1;
    send(8'hAA); send(8'h05);
    repeat (3) @(posedge clk); #1;
    check("overrun_pulses", 32'(evq.size()), 32'd0);
    check("overrun_payload_kept", 32'(dq.size()), 32'd3);
    out_ready = 1'b1;
    wait_done(10);

    // Reset mid-drain.
    out_ready = 1'b0;
    expect_ev(0, 3); expect_3byte();
    send_3byte();
    @(posedge clk); #1;
    check("drain_before_reset", 32'(out_valid), 32'd1);
    rst = 1'b0; #1;
    check("async_reset_outputs",
          32'({out_valid, pkt_ok, err_valid, overrun, out_last, err_code, pkt_len, out_data}), 32'd0);
    dq.delete(); evq.delete();
    @(posedge clk); #1 rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", 32'(out_valid), 32'd0);
    expect_ev(0, 0);
    send(8'hAA); send(8'h00); send(8'h00);
    wait_done(4);

    check("final_events_empty", 32'(evq.size()), 32'd0);
    check("final_data_empty", 32'(dq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
